// File: rtl/apb_master_bridge.sv
// APB requester: turns single valid/ready commands into APB SETUP->ACCESS transfers
// and returns read data, or a timeout error, on a valid/ready response port.
module apb_master_bridge #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);

    // A zero TIMEOUT still needs a 1-bit counter so the vector stays legal.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;

    assign cmd_ready = (state_q == IDLE) && !rsp_valid_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    always_ff @(posedge clk) begin
        if (PRESET) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        wait_cnt_d  = wait_cnt_q;

        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    paddr_d   = cmd_addr;
                    pwrite_d  = cmd_write;
                    pwdata_d  = cmd_wdata;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d  = 1'b1;
                wait_cnt_d = '0;
                state_d    = ACCESS;
            end
            ACCESS: begin
                // Completion takes priority over a timeout landing in the same cycle.
                if (PREADY) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                end else if (TIMEOUT_EN && (wait_cnt_q == CNT_LIMIT)) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else if (wait_cnt_q != CNT_MAX) begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed scenarios followed by random
// transactions, checked against a transaction-level model of the register slave.
module tb_apb_master_bridge;

    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic              clk;
    logic              PRESET;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;

    int checks = 0;
    int errors = 0;

    // refMem is what the model expects the slave to hold; slaveMem is what the
    // emulated slave actually stored from the DUT's APB signals.
    logic [DATA_W-1:0] refMem   [16];
    logic [DATA_W-1:0] slaveMem [16];

    apb_master_bridge #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .PRESET    (PRESET),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one command end to end; expectations come from the wait count alone.
    task automatic applyStimulus(input bit isWrite, input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] wdata, input int waits,
                                 input int rspDelay);
        bit                expErr;
        int                accessCycles;
        logic [DATA_W-1:0] expRdata;
        expErr       = (TIMEOUT != 0) && (waits >= TIMEOUT);
        accessCycles = expErr ? TIMEOUT : waits + 1;
        expRdata     = (isWrite || expErr) ? '0 : refMem[addr];
        if (isWrite && !expErr) refMem[addr] = wdata;

        checkOutput("cmd_ready_idle", 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b1;
        cmd_write = isWrite;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        tick();
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom_range(0, 1));
        cmd_addr  = 4'($urandom);
        cmd_wdata = $urandom;
        PREADY    = 1'($urandom_range(0, 1));
        PRDATA    = $urandom;
        checkOutput("setup_psel", 64'(PSEL), 64'(1));
        checkOutput("setup_penable", 64'(PENABLE), 64'(0));
        checkOutput("setup_pwrite", 64'(PWRITE), 64'(isWrite));
        checkOutput("setup_paddr", 64'(PADDR), 64'(addr));
        if (isWrite) checkOutput("setup_pwdata", 64'(PWDATA), 64'(wdata));
        checkOutput("setup_cmd_ready", 64'(cmd_ready), 64'(0));
        tick();

        for (int k = 0; k < accessCycles; k++) begin
            checkOutput("access_psel", 64'(PSEL), 64'(1));
            checkOutput("access_penable", 64'(PENABLE), 64'(1));
            checkOutput("access_pwrite", 64'(PWRITE), 64'(isWrite));
            checkOutput("access_paddr", 64'(PADDR), 64'(addr));
            if (isWrite) checkOutput("access_pwdata", 64'(PWDATA), 64'(wdata));
            if (k == waits) begin
                PREADY = 1'b1;
                PRDATA = slaveMem[PADDR];
                if (PWRITE) slaveMem[PADDR] = PWDATA;
            end else begin
                PREADY = 1'b0;
                PRDATA = $urandom;
            end
            tick();
        end
        PREADY = 1'($urandom_range(0, 1));
        PRDATA = $urandom;

        checkOutput("rsp_valid", 64'(rsp_valid), 64'(1));
        checkOutput("rsp_err", 64'(rsp_err), 64'(expErr));
        checkOutput("rsp_rdata", 64'(rsp_rdata), 64'(expRdata));
        checkOutput("rsp_psel", 64'(PSEL), 64'(0));
        checkOutput("rsp_penable", 64'(PENABLE), 64'(0));
        checkOutput("rsp_cmd_ready", 64'(cmd_ready), 64'(0));
        cmd_valid = 1'b1;
        for (int d = 0; d < rspDelay; d++) begin
            rsp_ready = 1'b0;
            tick();
            checkOutput("hold_rsp_valid", 64'(rsp_valid), 64'(1));
            checkOutput("hold_rsp_err", 64'(rsp_err), 64'(expErr));
            checkOutput("hold_rsp_rdata", 64'(rsp_rdata), 64'(expRdata));
            checkOutput("hold_cmd_ready", 64'(cmd_ready), 64'(0));
            checkOutput("hold_psel", 64'(PSEL), 64'(0));
        end
        rsp_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        checkOutput("ack_rsp_valid", 64'(rsp_valid), 64'(0));
        checkOutput("ack_psel", 64'(PSEL), 64'(0));
        checkOutput("ack_cmd_ready", 64'(cmd_ready), 64'(1));
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            refMem[i]   = '0;
            slaveMem[i] = '0;
        end
        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        tick();
        tick();

        $display("[TB] reset state");
        checkOutput("reset_psel", 64'(PSEL), 64'(0));
        checkOutput("reset_penable", 64'(PENABLE), 64'(0));
        checkOutput("reset_pwrite", 64'(PWRITE), 64'(0));
        checkOutput("reset_paddr", 64'(PADDR), 64'(0));
        checkOutput("reset_pwdata", 64'(PWDATA), 64'(0));
        checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        checkOutput("reset_rsp_rdata", 64'(rsp_rdata), 64'(0));
        checkOutput("reset_rsp_err", 64'(rsp_err), 64'(0));
        checkOutput("reset_cmd_ready", 64'(cmd_ready), 64'(1));
        PRESET = 1'b0;
        tick();

        $display("[TB] zero-wait write, waited read");
        applyStimulus(1'b1, 4'h3, 32'hDEADBEEF, 0, 0);
        applyStimulus(1'b1, 4'h5, 32'h12345678, 0, 0);
        applyStimulus(1'b0, 4'h5, 32'h0, 3, 0);

        $display("[TB] timeout and recovery");
        applyStimulus(1'b0, 4'h7, 32'h0, 40, 0);
        applyStimulus(1'b0, 4'h3, 32'h0, 0, 0);
        applyStimulus(1'b1, 4'h9, 32'hCAFE0001, TIMEOUT - 1, 0);
        applyStimulus(1'b1, 4'h9, 32'hCAFE0002, TIMEOUT, 0);
        applyStimulus(1'b0, 4'h9, 32'h0, TIMEOUT - 1, 0);

        $display("[TB] response backpressure");
        applyStimulus(1'b0, 4'h3, 32'h0, 0, 5);

        $display("[TB] reset during access");
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 4'h3;
        cmd_wdata = 32'h55AA55AA;
        tick();
        cmd_valid = 1'b0;
        tick();
        PREADY = 1'b0;
        checkOutput("rst_mid_penable_before", 64'(PENABLE), 64'(1));
        PRESET = 1'b1;
        tick();
        checkOutput("rst_mid_psel", 64'(PSEL), 64'(0));
        checkOutput("rst_mid_penable", 64'(PENABLE), 64'(0));
        checkOutput("rst_mid_rsp_valid", 64'(rsp_valid), 64'(0));
        PRESET = 1'b0;
        tick();
        checkOutput("rst_rel_cmd_ready", 64'(cmd_ready), 64'(1));
        checkOutput("rst_rel_rsp_valid", 64'(rsp_valid), 64'(0));
        checkOutput("rst_rel_psel", 64'(PSEL), 64'(0));
        applyStimulus(1'b0, 4'h3, 32'h0, 1, 0);

        $display("[TB] back-to-back");
        applyStimulus(1'b1, 4'h1, 32'h0000000A, 0, 0);
        applyStimulus(1'b0, 4'h1, 32'h0, 0, 0);

        $display("[TB] random transactions");
        for (int n = 0; n < 40; n++) begin
            int waits;
            waits = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TIMEOUT - 2, TIMEOUT + 3))
                                                : int'($urandom_range(0, 4));
            applyStimulus(1'($urandom_range(0, 1)), 4'($urandom), $urandom, waits,
                          int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
